// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-fetch slice of the 5-stage RISC-V core.
//   XLEN          : default data/address width
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) used for bubbles and flushes
//   fetch_entry_t : one fetched instruction together with the PC it came from
package riscv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular response buffer holding fetched {pc, instr} entries in order.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push / wdata : enqueue an entry (accepted when not full, or full with pop)
//   pop / rdata  : dequeue the head; rdata always shows the current head
//   clear        : empty the buffer; takes priority over push and pop
//   count, full, empty : occupancy status
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else                     return p + PW'(1);
  endfunction

  assign empty   = (count_r == '0);
  assign full    = (count_r == CW'(DEPTH));
  assign count   = count_r;
  assign rdata   = mem_r[rd_ptr_r];
  assign do_pop  = pop && !empty;
  // A push into a full buffer is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Entry storage; data path only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_r[wr_ptr_r] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (clear) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (do_pop)  rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit_checker.sv
// Structural invariants of the fetch unit.
//   count, inflight : buffered entries and outstanding memory requests
//   full, req_valid : buffer full flag and the outgoing request valid
module fetch_unit_checker #(
  parameter int BUF_DEPTH = 2
) (
  input logic                             clk,
  input logic                             rst_n,
  input logic [$clog2(BUF_DEPTH+1)-1:0]   count,
  input logic [$clog2(BUF_DEPTH+1)-1:0]   inflight,
  input logic                             full,
  input logic                             req_valid
);

  occupancy_bound: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(count) + int'(inflight)) <= BUF_DEPTH);

  full_blocks_request: assert property (@(posedge clk) disable iff (!rst_n)
    full |-> !req_valid);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues ready/valid requests,
// buffers in-order responses and drives the IF/ID register under the hazard
// unit's stall_f / stall_d / flush_d commands.
//   stall_f, stall_d, flush_d, pc_target_e : hazard controls and redirect target
//   imem_req_*  : request channel (valid/ready, word-aligned address)
//   imem_rsp_*  : response channel (in order, always accepted)
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID register outputs
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic [XLEN-1:0] pc_target_e,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [XLEN-1:0] pc_f_r;
  logic [CW-1:0]   inflight_r;
  logic [CW-1:0]   drop_r;
  logic [XLEN-1:0] pcq_r [BUF_DEPTH];
  logic [PW-1:0]   pcq_wr_r;
  logic [PW-1:0]   pcq_rd_r;

  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  fetch_entry_t    head;
  fetch_entry_t    rsp_entry;
  fetch_entry_t    d_src;
  logic            room;
  logic            req_fire;
  logic            rsp_keep;
  logic            fifo_push;
  logic            fifo_pop;
  logic            load_d;
  logic            bypass;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(BUF_DEPTH - 1)) return '0;
    else                         return p + PW'(1);
  endfunction

  // Outstanding requests count against buffer space so every response has a slot.
  assign room           = ({1'b0, inflight_r} + {1'b0, count}) < (CW+1)'(BUF_DEPTH);
  assign imem_req_valid = rst_n && !stall_f && !flush_d && room;
  assign imem_req_addr  = pc_f_r;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_entry.pc    = pcq_r[pcq_rd_r];
  assign rsp_entry.instr = imem_rsp_data;
  assign d_src           = bypass ? rsp_entry : head;

  // Steer each response into the buffer or straight into IF/ID.
  always_comb begin
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    load_d    = 1'b0;
    bypass    = 1'b0;
    // Responses owed to a squashed path, or landing on a flush, are discarded.
    rsp_keep  = imem_rsp_valid && (drop_r == '0) && !flush_d;
    if (flush_d) begin
      fifo_push = 1'b0;
    end else if (stall_d) begin
      fifo_push = rsp_keep;
    end else if (!empty) begin
      fifo_pop  = 1'b1;
      fifo_push = rsp_keep;
      load_d    = 1'b1;
    end else if (rsp_keep) begin
      load_d = 1'b1;
      bypass = 1'b1;
    end else begin
      load_d = 1'b0;
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clear (flush_d),
    .wdata (rsp_entry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Fetch PC, outstanding-request and squash counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_r     <= RESET_PC;
      inflight_r <= '0;
      drop_r     <= '0;
    end else begin
      case ({req_fire, imem_rsp_valid})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
      // Everything still outstanding after this cycle belongs to the old path.
      if (flush_d)
        drop_r <= inflight_r - (imem_rsp_valid ? CW'(1) : CW'(0));
      else if (imem_rsp_valid && (drop_r != '0))
        drop_r <= drop_r - CW'(1);
      if (flush_d)       pc_f_r <= pc_target_e;
      else if (req_fire) pc_f_r <= pc_f_r + XLEN'(4);
    end
  end

  // PC queue storage, written at request handshake.
  always_ff @(posedge clk) begin
    if (req_fire) pcq_r[pcq_wr_r] <= pc_f_r;
  end

  // PC queue pointers; every response (kept or dropped) retires one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcq_wr_r <= '0;
      pcq_rd_r <= '0;
    end else begin
      if (req_fire)       pcq_wr_r <= ptr_inc(pcq_wr_r);
      if (imem_rsp_valid) pcq_rd_r <= ptr_inc(pcq_rd_r);
    end
  end

  // IF/ID pipeline register: flush > stall > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (stall_d) begin
      valid_d <= valid_d;
    end else if (load_d) begin
      instr_d    <= d_src.instr;
      pc_d       <= d_src.pc;
      pc_plus4_d <= d_src.pc + XLEN'(4);
      valid_d    <= 1'b1;
    end else begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end
  end

  fetch_unit_checker #(.BUF_DEPTH(BUF_DEPTH)) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .count     (count),
    .inflight  (inflight_r),
    .full      (full),
    .req_valid (imem_req_valid)
  );

endmodule
